// File: rtl/sysbus_pkg.sv
// +-----------------------------------------------------------------------------+
// | Package     : sysbus_pkg                                                    |
// | Description : Shared constants and state encoding for the system-bus        |
// |               memory responder (tag field layout, line geometry, FSM).      |
// | Ports       : none                                                          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

package sysbus_pkg;

   // Tag layout: [12] read/write, [11:8] request type
   localparam int         TAG_READ_BIT     = 12;
   localparam int         TAG_TYPE_LSB     = 8;
   localparam int         TAG_TYPE_WIDTH   = 4;
   localparam logic [3:0] TAG_TYPE_MEMORY  = 4'b0001;

   // Line geometry: 64-byte lines of eight 64-bit words
   localparam int         BEATS_PER_LINE   = 8;
   localparam int         LINE_OFFSET_BITS = 6;
   localparam int         WORD_OFFSET_BITS = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAT    = 2'd1,
      RBURST = 2'd2,
      WDATA  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sysbus_mem_array.sv
// +-----------------------------------------------------------------------------+
// | Module      : sysbus_mem_array                                              |
// | Description : Single-port synchronous-read RAM backing store. One access    |
// |               per cycle: a write when we=1, otherwise a read whose data     |
// |               appears on rdata after the clock edge.                        |
// | Ports       : clk   - clock                                                 |
// |               we    - write enable                                          |
// |               addr  - word address                                          |
// |               wdata - write data                                            |
// |               rdata - registered read data                                  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sysbus_mem_array #(
   parameter int WORDS  = 4096,
   parameter int WIDTH  = 64,
   parameter int ADDR_W = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [WORDS];

   // Contents are deliberately not reset; the read register holds its value
   // across write cycles.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
// +-----------------------------------------------------------------------------+
// | Module      : sysbus_mem_responder                                          |
// | Description : Memory-side system-bus responder. Acknowledges memory-type    |
// |               requests, returns 8-beat line fills (each beat held until     |
// |               respack) and absorbs 8-beat line writes.                      |
// | Config      : SYSBUS_RESP_CRITICAL_WORD_FIRST_EN - read bursts start at     |
// |               the requested word and wrap inside the line; otherwise they   |
// |               start at word 0.                                              |
// | Ports       : clk, reset (async, active-high)                               |
// |               reqcyc/req/reqtag - request valid, address or data, tag       |
// |               reqack            - one-cycle acknowledge                     |
// |               respcyc/resp/resptag - response beat valid, data, tag         |
// |               respack           - initiator accepts current beat            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sysbus_mem_responder #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int MEM_WORDS      = 4096,
   parameter int READ_LATENCY   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] req,
   input  logic [BUS_TAG_WIDTH-1:0]  reqtag,
   output logic                      reqack,
   output logic [BUS_DATA_WIDTH-1:0] resp,
   output logic [BUS_TAG_WIDTH-1:0]  resptag,
   output logic                      respcyc,
   input  logic                      respack
);

   import sysbus_pkg::*;

   localparam int ADDR_W = $clog2(MEM_WORDS);
   localparam int OFF_W  = LINE_OFFSET_BITS - WORD_OFFSET_BITS;
   localparam int LINE_W = ADDR_W - OFF_W;
   localparam int CNT_W  = $clog2(READ_LATENCY + BEATS_PER_LINE);

   state_t                    state;
   logic [LINE_W-1:0]         line;
   logic [OFF_W-1:0]          ptr;
   logic [CNT_W-1:0]          cnt;

   logic [OFF_W-1:0]          req_word;
   logic                      accept;
   logic                      lat_done;
   logic                      last_beat;
   logic                      mem_we;
   logic [LINE_W-1:0]         mem_line;
   logic [OFF_W-1:0]          mem_off;
   logic [BUS_DATA_WIDTH-1:0] rdata;

`ifdef SYSBUS_RESP_CRITICAL_WORD_FIRST_EN
   assign req_word = req[LINE_OFFSET_BITS-1:WORD_OFFSET_BITS];
`else
   assign req_word = '0;
`endif

   assign accept    = (state == IDLE) && reqcyc &&
                      (reqtag[TAG_TYPE_LSB +: TAG_TYPE_WIDTH] == TAG_TYPE_MEMORY);
   assign lat_done  = (cnt == CNT_W'(READ_LATENCY - 1));
   assign last_beat = (cnt == CNT_W'(BEATS_PER_LINE - 1));

   // RAM address selection. The read data register must always hold the word
   // that becomes the next resp beat, so the address runs one beat ahead of
   // ptr (two ahead when the current beat is being accepted this cycle).
   // Offsets are OFF_W bits wide so they wrap inside the line, and dropping
   // the upper line bits wraps addresses beyond the array.
   always_comb begin
      mem_we   = 1'b0;
      mem_line = line;
      mem_off  = ptr;
      case (state)
         IDLE: begin
            mem_line = req[LINE_OFFSET_BITS +: LINE_W];
            mem_off  = req_word;
         end
         LAT: begin
            if (lat_done) begin
               mem_off = ptr + OFF_W'(1);
            end
         end
         RBURST: begin
            mem_off = respack ? ptr + OFF_W'(2) : ptr + OFF_W'(1);
         end
         WDATA: begin
            mem_we = reqcyc;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

   sysbus_mem_array #(
      .WORDS  (MEM_WORDS),
      .WIDTH  (BUS_DATA_WIDTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  ({mem_line, mem_off}),
      .wdata (req),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         reqack  <= 1'b0;
         respcyc <= 1'b0;
         resp    <= '0;
         resptag <= '0;
         line    <= '0;
         ptr     <= '0;
         cnt     <= '0;
      end else begin
         reqack <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  reqack  <= 1'b1;
                  resptag <= reqtag;
                  line    <= req[LINE_OFFSET_BITS +: LINE_W];
                  cnt     <= '0;
                  if (reqtag[TAG_READ_BIT]) begin
                     state <= LAT;
                     ptr   <= req_word;
                  end else begin
                     state <= WDATA;
                     ptr   <= '0;
                  end
               end
            end
            LAT: begin
               if (lat_done) begin
                  state   <= RBURST;
                  respcyc <= 1'b1;
                  resp    <= rdata;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RBURST: begin
               if (respack) begin
                  if (last_beat) begin
                     state   <= IDLE;
                     respcyc <= 1'b0;
                  end else begin
                     cnt  <= cnt + CNT_W'(1);
                     ptr  <= ptr + OFF_W'(1);
                     resp <= rdata;
                  end
               end
            end
            WDATA: begin
               if (reqcyc) begin
                  reqack <= 1'b1;
                  ptr    <= ptr + OFF_W'(1);
                  if (ptr == OFF_W'(BEATS_PER_LINE - 1)) begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/sysbus_mem_responder.md
# sysbus_mem_responder

Memory-side responder for the system bus: accepts address/tag requests from bus initiators such as the instruction cache, acknowledges them, and returns 64-byte line fills as eight 64-bit response beats, each held until the initiator acknowledges it. It also absorbs 8-beat line writes. It sits at the far end of the bus, behind the arbiter. It serves as the simulation backing store for fetch and data traffic.

## Interface
- BUS_DATA_WIDTH, 64, width of req/resp data
- BUS_TAG_WIDTH, 13, width of reqtag/resptag
- MEM_WORDS, 4096, backing-store depth in 64-bit words (power of two)
- READ_LATENCY, 4, cycles from reqack to first response beat (>=1)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reqcyc  in  1  request valid
- req  in  BUS_DATA_WIDTH  byte address (address cycle) or write data (data cycles)
- reqtag  in  BUS_TAG_WIDTH  [12]=1 read / 0 write; [11:8]=type, 4'b0001 memory
- reqack  out  1  one-cycle acknowledge of a request or write beat
- resp  out  BUS_DATA_WIDTH  read beat data
- resptag  out  BUS_TAG_WIDTH  tag of the request being answered
- respcyc  out  1  response beat valid
- respack  in  1  initiator accepts current beat

## Operation
- States: IDLE, LAT, RBURST, WDATA.
- IDLE: reqcyc=1 with reqtag[11:8]=4'b0001 is accepted; reqack=1 next cycle. Latch tag and line base = req[63:6]; word index = req[5:3].
- Other type codes: not acknowledged, stay IDLE.
- Read (reqtag[12]=1): IDLE->LAT; counter runs READ_LATENCY cycles; ->RBURST.
- RBURST: respcyc=1, resp=mem[line+beat], resptag=latched tag. Beat advances only in a cycle with respack=1; data stable otherwise. After beat 7 acked -> IDLE, respcyc=0.
- Write (reqtag[12]=0): IDLE->WDATA; each later cycle with reqcyc=1 writes req to mem[line+k], k=0..7, reqack=1 next cycle; after k=7 -> IDLE. No response beats.
- reqcyc outside IDLE/WDATA: ignored, no reqack; initiator holds request.
- Word index = (line*8 + beat) mod MEM_WORDS; addresses above the array wrap silently.
- respack while respcyc=0: ignored.

## Timing
- Reset values: reqack=0, respcyc=0, resp=0, resptag=0, state IDLE, counters 0. Array contents not reset.
- Reset mid-burst: outputs to reset values immediately; in-flight request dropped; partial writes already stored stay.
- Read: reqcyc sampled edge N -> reqack high cycle N+1 -> first respcyc cycle N+1+READ_LATENCY.
- Back-to-back beats: respack sampled at edge M -> next beat valid in cycle M+1; full-rate burst = 8 cycles.
- After last respack: respcyc low next cycle; next request accepted earliest one cycle later (IDLE sample).
- Write beat sampled edge M -> stored and reqack high cycle M+1.
- reqack always a single-cycle pulse per accepted cycle.

## Configuration
- SYSBUS_RESP_CRITICAL_WORD_FIRST_EN defined: read burst starts at the requested word index and wraps within the line (e.g. index 5: 5,6,7,0,1,2,3,4).
- Not defined: read burst always starts at word 0 regardless of req[5:3].
- Writes always start at word 0 in both builds.

## Structure
- Package sysbus_pkg: tag bit position TAG_READ_BIT=12, TAG_TYPE_MEMORY=4'b0001, BEATS_PER_LINE=8, LINE_OFFSET_BITS=6, state enum.
- Sub-module sysbus_mem_array: single-port synchronous-read RAM (MEM_WORDS x BUS_DATA_WIDTH), one read or write per cycle; responder pre-fetches the next beat so respack-to-next-beat latency stays 1.

## Test plan
- Preload mem[0x40..0x47 words]=0x100+i; read req=0x200, tag 13'h1100 -> reqack at +1, beats 0x100..0x107 starting +1+READ_LATENCY, resptag=13'h1100.
- Same read, respack low for 3 cycles on beat 2 -> resp/respcyc held constant, beat 3 follows the respack cycle by one.
- Read req=0x228 with macro defined -> beat order 0x105,0x106,0x107,0x100..0x104; undefined -> 0x100..0x107.
- Write req=0x400 tag 13'h0100 then 8 data beats 0xA0..0xA7 with gaps -> reqack per beat; subsequent read of 0x400 returns 0xA0..0xA7.
- Request with tag type 4'b0010 -> no reqack, state IDLE for 20 cycles.
- Assert reset during beat 4 of a read -> respcyc=0 same cycle; new read after release completes normally with 8 beats.
